pwd_load_ctrl: RTL and testbench
================================

Name: pwd_load_ctrl

Overview:
- Upstream control stage for the password cracker array.
- Accepts password characters one byte at a time over a valid/ready handshake and validates each against the cracker charset.
- Packs the characters into the array's 33-bit password bus and sequences the array's reset/run window.
- Captures the array's found/done status into a held result record with a cycle count, released on host acknowledge.

Parameters:
NCHAR, 4, password length in characters; password bus width is NCHAR*8+1
ARM_CYC, 2, cycles crk_rst stays high after a new password is presented (1..15)
CNT_W, 24, width of the run-cycle counter
TIMEOUT, 24'hFFFFFF, RUN cycle count at which the search is abandoned

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  character byte valid
in_data  in  8  ASCII character
in_ready  out  1  character accepted when in_valid&&in_ready
pwd_out  out  NCHAR*8+1  packed password to cracker array; first char at [NCHAR*8-1 -: 8]; MSB always 0
crk_rst  out  1  reset to cracker array (high = held in reset)
crk_found  in  1  cracker array found
crk_done  in  1  cracker array done
res_valid  out  1  result record held valid
res_found  out  1  password matched
res_timeout  out  1  search abandoned at TIMEOUT
res_cycles  out  CNT_W  RUN cycles until detection
res_ack  in  1  host consumed result
err_char  out  1  one-cycle pulse: illegal character rejected

Behaviour:
- Reset values:
  - Outputs: in_ready=0, pwd_out=0, crk_rst=1, res_*=0, err_char=0.
  - Internal: state=IDLE, char index=0, counter=0.
- Legal charset: 'a'..'z' (0x61-0x7A) and '0'..'9' (0x30-0x39), 36 symbols. Any other byte is illegal.
- FSM states: IDLE, LOAD, ARM, RUN, REPORT.
- IDLE/LOAD:
  - in_ready=1 (registered; 1 from the first cycle after reset release) and crk_rst=1.
  - Each accepted legal byte is written to the shadow slot at the current index; index increments; IDLE->LOAD on the first byte.
  - Illegal byte: consumed (handshake completes), err_char pulses for 1 cycle, shadow and index cleared, state -> IDLE.
  - NCHAR-th legal byte accepted in cycle T: shadow copied to pwd_out atomically (visible T+1), in_ready=0 from T+1, state -> ARM.
  - pwd_out never shows a partial password.
- ARM:
  - crk_rst held 1 for exactly ARM_CYC cycles, then state -> RUN.
  - crk_rst goes low in cycle T+1+ARM_CYC.
- RUN:
  - crk_rst=0; counter starts at 0 in the first RUN cycle and increments every cycle.
  - crk_found/crk_done are sampled each RUN cycle k (k = counter value).
  - Priority: crk_found -> res_found=1; else crk_done -> res_found=0; else counter==TIMEOUT -> res_timeout=1, res_found=0.
  - Any of these three events: res_cycles=k and res_valid=1 from the next cycle, state -> REPORT.
  - found and done in the same cycle resolve as found.
- REPORT:
  - crk_rst=0 (array keeps its final state); res_* held stable; in_ready=0.
  - res_ack while res_valid: res_valid drops the next cycle, crk_rst returns to 1, state -> IDLE, index=0.
  - res_ack in any other state is ignored.
- pwd_out is retained after REPORT until the next complete password is loaded.
- Counter never wraps; TIMEOUT ends RUN before any overflow.
- in_valid with in_ready=0 has no effect; the byte is not consumed.
- rst asserted in any state returns all registers to their reset values immediately. A partial load is discarded, and an in-progress RUN produces no result.

Test Plan:
- Load "ab12" (0x61,0x62,0x31,0x32) back-to-back -> pwd_out=33'h0_6162_3132 the cycle after the 4th byte; in_ready=0; crk_rst high 2 more cycles, then low.
- After "ab12", drive crk_found=1 in RUN cycle 10 -> res_valid=1, res_found=1, res_timeout=0, res_cycles=10, held until res_ack; then crk_rst=1, in_ready=1.
- Drive crk_done=1 with crk_found=0 at RUN cycle 5, then a second run with both high at cycle 7 -> results: first found=0 cycles=5; second found=1 cycles=7.
- Send 'a','B' -> err_char pulses 1 cycle on 'B'; then "zz99" loads pwd_out=33'h0_7A7A_3939, with no trace of 'a'.
- With TIMEOUT overridden to 20 and no status -> res_timeout=1, res_found=0, res_cycles=20.
- Assert rst after 2 bytes and again mid-RUN -> all outputs at reset values, crk_rst=1, res_valid never asserts; a following full load behaves normally.

Source files
------------

// File: rtl/pwd_load_ctrl.sv
// Password load controller for the cracker array.
// Collects charset-checked characters over a valid/ready handshake and packs
// them into the array's password bus. It holds the array in reset for a short
// arm window and then lets it run. The first found, done or timeout event is
// captured with its run-cycle count and held until the host acknowledges it.
module pwd_load_ctrl #(
  parameter int               NCHAR   = 4,
  parameter int               ARM_CYC = 2,
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] TIMEOUT = {CNT_W{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic [NCHAR*8:0]   pwd_out,
  output logic               crk_rst,
  input  logic               crk_found,
  input  logic               crk_done,
  output logic               res_valid,
  output logic               res_found,
  output logic               res_timeout,
  output logic [CNT_W-1:0]   res_cycles,
  input  logic               res_ack,
  output logic               err_char
);

  localparam int               IDX_W    = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHAR - 1);
  localparam logic [3:0]       ARM_LAST = 4'(ARM_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_REPORT
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         arm_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [NCHAR*8-1:0] shadow;
  logic [NCHAR*8-1:0] shadow_nxt;
  logic               char_ok;
  logic               take;

  // Only lowercase letters and digits belong to the cracker charset.
  assign char_ok = ((in_data >= 8'h61) && (in_data <= 8'h7A)) ||
                   ((in_data >= 8'h30) && (in_data <= 8'h39));
  assign take    = in_valid && in_ready;

  // Shadow password with the incoming byte dropped into the current slot.
  always_comb begin
    // NOTE: default assignment first so no path leaves shadow_nxt unassigned (no latch).
    shadow_nxt = shadow;
    shadow_nxt[NCHAR*8-1-8*int'(idx) -: 8] = in_data;
  end

  // Load/arm/run/report sequencer with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      arm_cnt     <= '0;
      cnt         <= '0;
      // NOTE: the shadow buffer is reset too, so a partial load can never leak into a later password.
      shadow      <= '0;
      in_ready    <= 1'b0;
      pwd_out     <= '0;
      crk_rst     <= 1'b1;
      res_valid   <= 1'b0;
      res_found   <= 1'b0;
      res_timeout <= 1'b0;
      res_cycles  <= '0;
      err_char    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      err_char <= 1'b0;
      unique case (state)
        S_IDLE, S_LOAD: begin
          in_ready <= 1'b1;
          crk_rst  <= 1'b1;
          if (take) begin
            if (!char_ok) begin
              // A bad byte is consumed and discards the partial password.
              err_char <= 1'b1;
              shadow   <= '0;
              idx      <= '0;
              state    <= S_IDLE;
            end else if (idx == LAST_IDX) begin
              // The complete password is published in one step; the bus never shows a partial one.
              pwd_out  <= {1'b0, shadow_nxt};
              shadow   <= shadow_nxt;
              idx      <= '0;
              in_ready <= 1'b0;
              arm_cnt  <= '0;
              state    <= S_ARM;
            end else begin
              shadow <= shadow_nxt;
              idx    <= idx + 1'b1;
              state  <= S_LOAD;
            end
          end
        end

        S_ARM: begin
          in_ready <= 1'b0;
          if (arm_cnt == ARM_LAST) begin
            crk_rst <= 1'b0;
            cnt     <= '0;
            state   <= S_RUN;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end

        S_RUN: begin
          in_ready <= 1'b0;
          crk_rst  <= 1'b0;
          if (crk_found || crk_done || (cnt == TIMEOUT)) begin
            // Found outranks done, and both outrank the timeout in the same cycle.
            res_found   <= crk_found;
            res_timeout <= !crk_found && !crk_done;
            res_cycles  <= cnt;
            res_valid   <= 1'b1;
            state       <= S_REPORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_REPORT: begin
          in_ready <= 1'b0;
          crk_rst  <= 1'b0;
          if (res_ack) begin
            res_valid <= 1'b0;
            crk_rst   <= 1'b1;
            in_ready  <= 1'b1;
            idx       <= '0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwd_load_ctrl.sv
// Randomised self-checking bench for pwd_load_ctrl. A transaction-level model
// predicts the packed password from the byte stream. It predicts the result
// record from the earliest of the found cycle, the done cycle and the timeout.
module tb_pwd_load_ctrl;

  localparam int NCHAR   = 4;
  localparam int ARM_CYC = 2;
  localparam int CNT_W   = 24;
  localparam int TO      = 20;
  localparam int NEVER   = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic [NCHAR*8:0] pwd_out;
  logic             crk_rst;
  logic             crk_found;
  logic             crk_done;
  logic             res_valid;
  logic             res_found;
  logic             res_timeout;
  logic [CNT_W-1:0] res_cycles;
  logic             res_ack;
  logic             err_char;

  int               total = 0;
  int               bad   = 0;
  logic [NCHAR*8:0] prev_pwd = '0;

  pwd_load_ctrl #(
    .NCHAR  (NCHAR),
    .ARM_CYC(ARM_CYC),
    .CNT_W  (CNT_W),
    .TIMEOUT(24'd20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .pwd_out    (pwd_out),
    .crk_rst    (crk_rst),
    .crk_found  (crk_found),
    .crk_done   (crk_done),
    .res_valid  (res_valid),
    .res_found  (res_found),
    .res_timeout(res_timeout),
    .res_cycles (res_cycles),
    .res_ack    (res_ack),
    .err_char   (err_char)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [7:0] b);
    return b inside {[8'h61:8'h7A], [8'h30:8'h39]};
  endfunction

  function automatic logic [7:0] rand_legal();
    int r;
    r = $urandom_range(0, 35);
    return (r < 26) ? 8'(8'h61 + r) : 8'(8'h30 + r - 26);
  endfunction

  function automatic logic [7:0] rand_illegal();
    logic [7:0] b;
    b = 8'($urandom);
    while (legal(b)) b = 8'($urandom);
    return b;
  endfunction

  // Asynchronous reset from any state: every output must take its reset value at once.
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; crk_found = 1'b0; crk_done = 1'b0; res_ack = 1'b0;
    #1;
    prev_pwd = '0;
    chk("rst_ready", in_ready, 0);
    chk("rst_pwd", pwd_out, 0);
    chk("rst_crk", crk_rst, 1);
    chk("rst_res", {res_valid, res_found, res_timeout, res_cycles}, 0);
    chk("rst_err", err_char, 0);
    step();
    step();
    chk("rst_hold_valid", res_valid, 0);
    rst = 1'b0;
    chk("rel_ready0", in_ready, 0);
    step();
    chk("rel_ready1", in_ready, 1);
    chk("rel_crk", crk_rst, 1);
  endtask

  // Feeds a byte stream until a complete legal password is accepted.
  task automatic load_pwd(input logic [7:0] chars[$]);
    logic [7:0]       q[$];
    logic [NCHAR*8:0] p;
    foreach (chars[i]) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_data = 8'($urandom); res_ack = 1'($urandom);
        step();
        chk("gap_ready", in_ready, 1);
        chk("gap_err", err_char, 0);
        chk("gap_pwd", pwd_out, prev_pwd);
        chk("gap_valid", res_valid, 0);
      end
      res_ack = 1'b0;
      in_valid = 1'b1; in_data = chars[i];
      chk("byte_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      if (!legal(chars[i])) begin
        chk("err_pulse", err_char, 1);
        chk("err_pwd", pwd_out, prev_pwd);
        q.delete();
      end else begin
        chk("err_quiet", err_char, 0);
        q.push_back(chars[i]);
        if (q.size() == NCHAR) begin
          p = '0;
          foreach (q[j]) p = (p << 8) | {25'd0, q[j]};
          prev_pwd = p;
          chk("load_pwd", pwd_out, prev_pwd);
          chk("load_ready", in_ready, 0);
          chk("load_crk", crk_rst, 1);
          return;
        end
        chk("partial_pwd", pwd_out, prev_pwd);
      end
    end
  endtask

  // Arm window, run with status edges at cycles kf/kd, report and acknowledge.
  // abort_k >= 0 asserts rst in that RUN cycle instead of finishing the run.
  task automatic arm_run(input int kf, input int kd, input int ack_dly, input int abort_k);
    int e;
    bit exp_found, exp_to;
    repeat (ARM_CYC - 1) begin
      in_valid = 1'($urandom); in_data = 8'($urandom); res_ack = 1'($urandom);
      step();
      chk("arm_crk", crk_rst, 1);
      chk("arm_ready", in_ready, 0);
    end
    in_valid = 1'($urandom); in_data = 8'($urandom); res_ack = 1'($urandom);
    step();
    chk("run_crk", crk_rst, 0);
    e = TO;
    if (kd < e) e = kd;
    if (kf < e) e = kf;
    exp_found = (kf == e);
    exp_to    = (kf != e) && (kd != e);
    for (int k = 0; k <= e; k++) begin
      if (k == abort_k) begin
        do_reset();
        return;
      end
      crk_found = (k >= kf); crk_done = (k >= kd);
      in_valid = 1'($urandom); in_data = 8'($urandom); res_ack = 1'($urandom);
      chk("run_novalid", res_valid, 0);
      chk("run_pwd", pwd_out, prev_pwd);
      step();
    end
    res_ack = 1'b0;
    chk("res_valid", res_valid, 1);
    chk("res_found", res_found, exp_found);
    chk("res_timeout", res_timeout, exp_to);
    chk("res_cycles", res_cycles, e);
    chk("rep_crk", crk_rst, 0);
    chk("rep_ready", in_ready, 0);
    for (int d = 0; d < ack_dly; d++) begin
      crk_found = 1'($urandom); crk_done = 1'($urandom);
      in_valid = 1'($urandom); in_data = 8'($urandom);
      step();
      chk("hold_res", {res_valid, res_found, res_timeout, res_cycles},
          {1'b1, exp_found, exp_to, CNT_W'(e)});
    end
    res_ack = 1'b1;
    step();
    res_ack = 1'b0; in_valid = 1'b0; crk_found = 1'b0; crk_done = 1'b0;
    chk("ack_valid", res_valid, 0);
    chk("ack_crk", crk_rst, 1);
    chk("ack_ready", in_ready, 1);
    chk("ack_pwd", pwd_out, prev_pwd);
  endtask

  task automatic gen(output logic [7:0] q[$]);
    q.delete();
    if ($urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(0, 3)) q.push_back(rand_legal());
      q.push_back(rand_illegal());
    end
    repeat (NCHAR) q.push_back(rand_legal());
  endtask

  initial begin
    logic [7:0] s[$];
    int kf, kd, ab;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    crk_found = 1'b0; crk_done = 1'b0; res_ack = 1'b0;
    @(posedge clk);
    do_reset();

    // "ab12" with found at run cycle 10.
    s = '{8'h61, 8'h62, 8'h31, 8'h32};
    load_pwd(s);
    chk("ab12_lit", pwd_out, 33'h0_6162_3132);
    arm_run(10, NEVER, 2, -1);

    // done-only at cycle 5, then found and done together at cycle 7.
    gen(s); load_pwd(s); arm_run(NEVER, 5, 1, -1);
    gen(s); load_pwd(s); arm_run(7, 7, 0, -1);

    // 'a','B' rejects the partial load; "zz99" then loads cleanly and times out.
    s = '{8'h61, 8'h42, 8'h7A, 8'h7A, 8'h39, 8'h39};
    load_pwd(s);
    chk("zz99_lit", pwd_out, 33'h0_7A7A_3939);
    arm_run(NEVER, NEVER, 1, -1);

    // Reset after two bytes, then reset in the middle of a run.
    in_valid = 1'b1; in_data = 8'h78; step();
    in_data = 8'h79; step();
    do_reset();
    gen(s); load_pwd(s); arm_run(NEVER, NEVER, 0, 6);
    repeat (3) begin
      step();
      chk("post_abort_valid", res_valid, 0);
    end
    gen(s); load_pwd(s); arm_run(3, NEVER, 1, -1);

    // Random sessions.
    repeat (40) begin
      gen(s);
      kf = $urandom_range(0, 24);
      kd = $urandom_range(0, 24);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : -1;
      load_pwd(s);
      arm_run(kf, kd, $urandom_range(0, 3), ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
